// File: rtl/reg_forward_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : reg_forward_ctrl
//  Description : Pipeline destination tracker and RAW-hazard resolver for the
//                8x16 register file. Records EX/MEM/WB destinations, drives
//                the file write port at WB, selects forwarding sources for
//                the Bus1/Bus2 operand muxes and inserts a one-cycle
//                load-use stall.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_forward_ctrl #(
    parameter int REG_AW    = 3,
    parameter int ZERO_HARD = 0,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwr,
    input  logic              id_is_load,
    input  logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall,
    output logic              rf_regwr,
    output logic [REG_AW-1:0] rf_rd,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Operand mux select encoding shared by Bus1 and Bus2.
    localparam logic [1:0] c_FWD_FILE = 2'b00;
    localparam logic [1:0] c_FWD_EX   = 2'b01;
    localparam logic [1:0] c_FWD_MEM  = 2'b10;
    localparam logic [1:0] c_FWD_WB   = 2'b11;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    // Destination record carried down the pipe. The load flag only matters
    // while the instruction sits in EX (its data is not ready there), so it
    // is kept beside the EX record rather than in every stage.
    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              wr;
    } dest_t;

    dest_t            r_ex;
    logic             r_ex_ld;
    dest_t            r_mem;
    dest_t            r_wb;
    logic [CNT_W-1:0] r_stall_cnt;

    dest_t            w_ex_next;
    logic             w_ex_ld_next;

    logic             w_rs1_live;
    logic             w_rs2_live;

    logic             w_ex_hit_a;
    logic             w_mem_hit_a;
    logic             w_wb_hit_a;
    logic             w_ex_hit_b;
    logic             w_mem_hit_b;
    logic             w_wb_hit_b;

    logic             w_hazard;
    logic             w_stall;

    // A source can only be matched when decode holds a real instruction that
    // actually reads it. With a hardwired R0, reads of R0 always come from
    // the file (which returns zero), so R0 never matches.
    generate
        if (ZERO_HARD != 0) begin : g_zero_hard
            assign w_rs1_live = id_valid & id_use_rs1 & (id_rs1 != '0);
            assign w_rs2_live = id_valid & id_use_rs2 & (id_rs2 != '0);
        end else begin : g_zero_soft
            assign w_rs1_live = id_valid & id_use_rs1;
            assign w_rs2_live = id_valid & id_use_rs2;
        end
    endgenerate

    // Per-stage hits: a stage matches only if it holds a live writer whose
    // destination equals the source index. Bubbles (v=0) never match.
    always_comb begin
        w_ex_hit_a  = w_rs1_live & r_ex.v  & r_ex.wr  & (r_ex.rd  == id_rs1);
        w_mem_hit_a = w_rs1_live & r_mem.v & r_mem.wr & (r_mem.rd == id_rs1);
        w_wb_hit_a  = w_rs1_live & r_wb.v  & r_wb.wr  & (r_wb.rd  == id_rs1);
        w_ex_hit_b  = w_rs2_live & r_ex.v  & r_ex.wr  & (r_ex.rd  == id_rs2);
        w_mem_hit_b = w_rs2_live & r_mem.v & r_mem.wr & (r_mem.rd == id_rs2);
        w_wb_hit_b  = w_rs2_live & r_wb.v  & r_wb.wr  & (r_wb.rd  == id_rs2);
    end

    // Bus1 select: the youngest producer wins. A load in EX has no data yet,
    // so it is skipped here; the stall covers that case and the value picked
    // in that cycle is not consumed.
    always_comb begin
        fwd_a = c_FWD_FILE;
        if (w_ex_hit_a && !r_ex_ld) begin
            fwd_a = c_FWD_EX;
        end else if (w_mem_hit_a) begin
            fwd_a = c_FWD_MEM;
        end else if (w_wb_hit_a) begin
            fwd_a = c_FWD_WB;
        end
    end

    // Bus2 select, same priority as Bus1.
    always_comb begin
        fwd_b = c_FWD_FILE;
        if (w_ex_hit_b && !r_ex_ld) begin
            fwd_b = c_FWD_EX;
        end else if (w_mem_hit_b) begin
            fwd_b = c_FWD_MEM;
        end else if (w_wb_hit_b) begin
            fwd_b = c_FWD_WB;
        end
    end

    // Load-use detection. A flushed instruction is discarded anyway, so it
    // must not hold the front end or be counted.
    always_comb begin
        w_hazard = (w_ex_hit_a | w_ex_hit_b) & r_ex_ld;
        w_stall  = w_hazard & ~flush;
    end

    assign stall = w_stall;

    // Record entering EX: a bubble whenever decode is stalled, flushed or
    // empty; otherwise the decoded destination information.
    always_comb begin
        w_ex_next    = '0;
        w_ex_ld_next = 1'b0;
        if (id_valid && !w_stall && !flush) begin
            w_ex_next.v  = 1'b1;
            w_ex_next.rd = id_rd;
            w_ex_next.wr = id_regwr;
            w_ex_ld_next = id_is_load;
        end
    end

    // Pipeline advance, every cycle. Reset clears all records so nothing
    // in flight can reach the register file afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex    <= '0;
            r_ex_ld <= 1'b0;
            r_mem   <= '0;
            r_wb    <= '0;
        end else begin
            r_ex    <= w_ex_next;
            r_ex_ld <= w_ex_ld_next;
            r_mem   <= r_ex;
            r_wb    <= r_mem;
        end
    end

    // Saturating count of stall cycles; it sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
        end
    end

    assign stall_cnt = r_stall_cnt;

    // Write port comes straight from the WB record, so there is no path from
    // decode inputs to the file controls. The file writes on the edge that
    // closes the WB cycle; a read of that register in the same cycle is
    // served by the WB forward select.
    assign rf_regwr = r_wb.v & r_wb.wr;
    assign rf_rd    = r_wb.rd;

endmodule
`default_nettype wire
